// File: rtl/program_loader.sv
// Boot-time program loader: receives a framed byte stream, writes 16-bit big-endian
// words into program memory from address 0, verifies an 8-bit checksum and gates CPU reset.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | after reset, waiting for start; CPU held
// SYNC    | discarding bytes until 0xA5
// LEN_HI  | expecting length high byte
// LEN_LO  | expecting length low byte; length validated here
// DATA_HI | expecting high byte of next word
// DATA_LO | expecting low byte; word written the following cycle
// CHECK   | expecting checksum byte
// DONE    | image good, CPU released
// ERROR   | bad length or checksum, CPU held
module program_loader #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  rx_ready,
    output logic                  mem_WE,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_writeData,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [15:0] DEPTH_W = 16'(DEPTH);
    localparam logic [7:0]  SYNC_BYTE = 8'hA5;

    typedef enum logic [3:0] {
        S_IDLE, S_SYNC, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHECK, S_DONE, S_ERROR
    } state_t;

    state_t          state, state_next;
    logic [7:0]      len_hi_q;
    logic [15:0]     len_q;
    logic [7:0]      hi_q;
    logic [CW-1:0]   cnt_q;
    logic [7:0]      sum_q;

    logic            xfer;
    logic [15:0]     len_full;
    logic            len_bad;
    logic [CW-1:0]   cnt_inc;
    logic [7:0]      sum_add;
    logic            last_word;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        rx_ready   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        error      = 1'b0;
        cpu_hold   = 1'b1;
        state_next = state;
        case (state)
            S_SYNC, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHECK: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
            end
            S_DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
            end
            S_ERROR: error = 1'b1;
            default: ;
        endcase

        xfer      = rx_valid & rx_ready;
        len_full  = {len_hi_q, rx_data};
        len_bad   = (len_full == 16'd0) || (len_full > DEPTH_W);
        cnt_inc   = cnt_q + CW'(1);
        sum_add   = sum_q + rx_data;
        last_word = (16'(cnt_inc) == len_q);

        case (state)
            S_IDLE, S_DONE, S_ERROR: if (start) state_next = S_SYNC;
            S_SYNC:    if (xfer && rx_data == SYNC_BYTE) state_next = S_LEN_HI;
            S_LEN_HI:  if (xfer) state_next = S_LEN_LO;
            S_LEN_LO:  if (xfer) state_next = len_bad ? S_ERROR : S_DATA_HI;
            S_DATA_HI: if (xfer) state_next = S_DATA_LO;
            S_DATA_LO: if (xfer) state_next = last_word ? S_CHECK : S_DATA_HI;
            S_CHECK:   if (xfer) state_next = (rx_data == sum_q) ? S_DONE : S_ERROR;
            default:   state_next = S_IDLE;
        endcase
    end

    // Datapath registers; mem_WE is a single-cycle strobe following the lo-byte handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_hi_q      <= '0;
            len_q         <= '0;
            hi_q          <= '0;
            cnt_q         <= '0;
            sum_q         <= '0;
            mem_WE        <= 1'b0;
            mem_address   <= '0;
            mem_writeData <= '0;
        end else begin
            mem_WE <= 1'b0;
            if (xfer) begin
                case (state)
                    S_LEN_HI: len_hi_q <= rx_data;
                    S_LEN_LO: begin
                        len_q <= len_full;
                        cnt_q <= '0;
                        sum_q <= '0;
                    end
                    S_DATA_HI: begin
                        hi_q  <= rx_data;
                        sum_q <= sum_add;
                    end
                    S_DATA_LO: begin
                        sum_q         <= sum_add;
                        mem_writeData <= DATA_WIDTH'({hi_q, rx_data});
                        mem_address   <= cnt_q[ADDR_WIDTH-1:0];
                        mem_WE        <= 1'b1;
                        cnt_q         <= cnt_inc;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
